// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive frame checker.
package gmii_rx_pkg;

  typedef enum logic [1:0] {StIdle, StPre, StBody, StDrop} state_e;

  localparam int unsigned ErrPre   = 0;
  localparam int unsigned ErrRxEr  = 1;
  localparam int unsigned ErrRunt  = 2;
  localparam int unsigned ErrGiant = 3;
  localparam int unsigned ErrCrc   = 4;

  localparam logic [31:0] CrcResidue  = 32'hC704DD7B;
  localparam logic [31:0] CrcSeed     = 32'hFFFFFFFF;
  localparam logic [7:0]  Preamble    = 8'h55;
  localparam logic [7:0]  Sfd         = 8'hD5;
  localparam logic [2:0]  MaxPreamble = 3'd7;

  // GMII delivers bit 0 first; the MSB-first CRC core wants it at the top.
  function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the MSB-first CRC-32 (poly 0x04C11DB7), no reflection or final xor.
module crc32_d8 (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);
  localparam logic [31:0] Poly = 32'h04C11DB7;

  always_comb begin
    next_crc = crc;
    for (int i = 7; i >= 0; i--) begin
      if (next_crc[31] ^ data[i]) next_crc = {next_crc[30:0], 1'b0} ^ Poly;
      else                        next_crc = {next_crc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/gmii_rx_frame_check.sv
// GMII RX front end: strips preamble/SFD, checks FCS, length and RX_ER, emits the frame body.
// Statistics counters exist only when GMII_RX_STATS_EN is defined; otherwise stat_* read 0.
module gmii_rx_frame_check
  import gmii_rx_pkg::*;
#(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1522
) (
  input  logic        GMII_RX_CLK,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_good,
  output logic [4:0]  out_err,
  output logic [31:0] stat_frames_ok,
  output logic [15:0] stat_crc_err,
  output logic [15:0] stat_other_err
);

  localparam logic [10:0] MinN   = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] GiantN = 11'(MAX_FRAME_BYTES + 1);
  localparam logic [10:0] FcsN   = 11'd5;

  state_e          state_q;
  logic [2:0]      pre_cnt_q;
  logic [10:0]     n_q;
  logic [31:0]     crc_q;
  logic [31:0]     crc_next;
  logic [4:0][7:0] hold_q;
  logic            sof_pend_q;
  logic            rx_er_q;
  logic [7:0]      rxd_rev;
  logic            giant;
  logic            body_end;
  logic            pre_err;
  logic [4:0]      verdict_err;

  assign rxd_rev = bit_reverse8(gmii_rxd);

  crc32_d8 u_crc (
    .crc      (crc_q),
    .data     (rxd_rev),
    .next_crc (crc_next)
  );

  always_comb begin
    giant    = (state_q == StBody) && (n_q == GiantN);
    body_end = (state_q == StBody) && (giant || !gmii_rx_dv);
    pre_err  = 1'b0;
    if (gmii_rx_dv) begin
      if (state_q == StIdle) begin
        pre_err = (gmii_rxd != Preamble);
      end else if (state_q == StPre) begin
        pre_err = (gmii_rxd == Preamble) ? (pre_cnt_q == MaxPreamble) : (gmii_rxd != Sfd);
      end
    end
    verdict_err         = '0;
    verdict_err[ErrPre] = pre_err;
    if (body_end) begin
      verdict_err[ErrRxEr]  = rx_er_q;
      verdict_err[ErrRunt]  = !giant && (n_q < MinN);
      verdict_err[ErrGiant] = giant;
      verdict_err[ErrCrc]   = !giant && (crc_q != CrcResidue);
    end
  end

  always_ff @(posedge GMII_RX_CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      pre_cnt_q  <= '0;
      n_q        <= '0;
      crc_q      <= '0;
      hold_q     <= '0;
      sof_pend_q <= 1'b0;
      rx_er_q    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_good   <= 1'b0;
      out_err    <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_good  <= 1'b0;
      out_err   <= '0;
      unique case (state_q)
        StIdle: begin
          if (gmii_rx_dv) begin
            if (pre_err) begin
              state_q <= StDrop;
            end else begin
              state_q   <= StPre;
              pre_cnt_q <= 3'd1;
            end
          end
        end
        StPre: begin
          if (!gmii_rx_dv) begin
            state_q <= StIdle;
          end else if (pre_err) begin
            state_q <= StDrop;
          end else if (gmii_rxd == Sfd) begin
            state_q    <= StBody;
            n_q        <= '0;
            crc_q      <= CrcSeed;
            sof_pend_q <= 1'b1;
            rx_er_q    <= 1'b0;
          end else begin
            pre_cnt_q <= pre_cnt_q + 3'd1;
          end
        end
        StBody: begin
          if (body_end) begin
            // The four youngest held bytes are the FCS; the oldest is the last payload byte.
            if (n_q >= FcsN) begin
              out_valid <= 1'b1;
              out_data  <= hold_q[4];
              out_sof   <= sof_pend_q;
              out_eof   <= 1'b1;
              out_good  <= (verdict_err == '0);
              out_err   <= verdict_err;
            end
            sof_pend_q <= 1'b0;
            state_q    <= (giant && gmii_rx_dv) ? StDrop : StIdle;
          end else begin
            crc_q  <= crc_next;
            n_q    <= (n_q == '1) ? n_q : n_q + 11'd1;
            hold_q <= {hold_q[3:0], gmii_rxd};
            if (gmii_rx_er) rx_er_q <= 1'b1;
            if (n_q >= FcsN) begin
              out_valid  <= 1'b1;
              out_data   <= hold_q[4];
              out_sof    <= sof_pend_q;
              sof_pend_q <= 1'b0;
            end
          end
        end
        StDrop: begin
          if (!gmii_rx_dv) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef GMII_RX_STATS_EN
  // Verdicts are registered once so the counters move the cycle after out_eof.
  logic       evt_q;
  logic [4:0] evt_err_q;

  always_ff @(posedge GMII_RX_CLK) begin
    if (reset) begin
      evt_q          <= 1'b0;
      evt_err_q      <= '0;
      stat_frames_ok <= '0;
      stat_crc_err   <= '0;
      stat_other_err <= '0;
    end else begin
      evt_q     <= body_end || pre_err;
      evt_err_q <= verdict_err;
      if (evt_q) begin
        if (evt_err_q == '0 && stat_frames_ok != '1) stat_frames_ok <= stat_frames_ok + 32'd1;
        if (evt_err_q[ErrCrc] && stat_crc_err != '1) stat_crc_err <= stat_crc_err + 16'd1;
        if ((|evt_err_q[3:0]) && stat_other_err != '1) stat_other_err <= stat_other_err + 16'd1;
      end
    end
  end
`else
  assign stat_frames_ok = '0;
  assign stat_crc_err   = '0;
  assign stat_other_err = '0;
`endif

endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// Scoreboard bench for gmii_rx_frame_check: expected beats are queued as frames are driven.
module tb_gmii_rx_frame_check;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       good;
    logic [4:0] err;
  } beat_t;

`ifdef GMII_RX_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        GMII_RX_CLK;
  logic        reset;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_good;
  logic [4:0]  out_err;
  logic [31:0] stat_frames_ok;
  logic [15:0] stat_crc_err;
  logic [15:0] stat_other_err;

  beat_t       sb[$];
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_ok;
  logic [15:0] exp_crc;
  logic [15:0] exp_other;

  gmii_rx_frame_check dut (
    .GMII_RX_CLK    (GMII_RX_CLK),
    .reset          (reset),
    .gmii_rxd       (gmii_rxd),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_sof        (out_sof),
    .out_eof        (out_eof),
    .out_good       (out_good),
    .out_err        (out_err),
    .stat_frames_ok (stat_frames_ok),
    .stat_crc_err   (stat_crc_err),
    .stat_other_err (stat_other_err)
  );

  initial GMII_RX_CLK = 1'b0;
  always #5 GMII_RX_CLK = ~GMII_RX_CLK;

  // Scoreboard consumer: every valid beat must match the head of the queue.
  always @(negedge GMII_RX_CLK) begin
    if (out_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got data=%h sof=%b eof=%b, required no beat",
                 out_data, out_sof, out_eof);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (out_data !== e.data || out_sof !== e.sof || out_eof !== e.eof ||
            (e.eof && (out_good !== e.good || out_err !== e.err))) begin
          n_bad++;
          $display("FAIL beat: got data=%h sof=%b eof=%b good=%b err=%b, required data=%h sof=%b eof=%b good=%b err=%b",
                   out_data, out_sof, out_eof, out_good, out_err,
                   e.data, e.sof, e.eof, e.good, e.err);
        end
      end
    end
  end

  // Independent reflected CRC-32; the FCS is its complement, sent low byte first.
  function automatic byte_q_t add_fcs(input byte_q_t p);
    logic [31:0] c;
    byte_q_t     q;
    c = 32'hFFFFFFFF;
    foreach (p[i]) begin
      q.push_back(p[i]);
      c = c ^ {24'd0, p[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    q.push_back(c[23:16]);
    q.push_back(c[31:24]);
    return q;
  endfunction

  function automatic byte_q_t make_body(input int payload_len);
    byte_q_t p;
    for (int i = 0; i < payload_len; i++) p.push_back(8'($urandom_range(0, 255)));
    return add_fcs(p);
  endfunction

  function automatic byte_q_t with_preamble(input byte_q_t body);
    byte_q_t q;
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    foreach (body[i]) q.push_back(body[i]);
    return q;
  endfunction

  task automatic push_expect(input byte_q_t body, input int nbeats, input logic [4:0] err,
                             input bit with_eof);
    for (int i = 0; i < nbeats; i++) begin
      beat_t b;
      b.data = body[i];
      b.sof  = (i == 0);
      b.eof  = with_eof && (i == nbeats - 1);
      b.good = (err == 5'd0);
      b.err  = err;
      sb.push_back(b);
    end
  endtask

  // Drives the bytes back to back, then one DV-low cycle.
  task automatic drive(input byte_q_t bytes, input int er_at);
    foreach (bytes[i]) begin
      @(negedge GMII_RX_CLK);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = bytes[i];
      gmii_rx_er = (i == er_at);
    end
    @(negedge GMII_RX_CLK);
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    gmii_rx_er = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge GMII_RX_CLK);
    repeat (3) @(negedge GMII_RX_CLK);
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    gmii_rx_er = 1'b0;
    repeat (3) @(negedge GMII_RX_CLK);
    n_cmp++;
    if ({out_data, out_valid, out_sof, out_eof, out_good, out_err} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, required 0",
               {out_data, out_valid, out_sof, out_eof, out_good, out_err});
    end
    n_cmp++;
    if ({stat_frames_ok, stat_crc_err, stat_other_err} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_stats: got %0d/%0d/%0d, required 0/0/0",
               stat_frames_ok, stat_crc_err, stat_other_err);
    end
    reset = 1'b0;
    @(negedge GMII_RX_CLK);
  endtask

  task automatic test_good_frame();
    byte_q_t body;
    body = make_body(60);
    push_expect(body, 60, 5'b00000, 1'b1);
    drive(with_preamble(body), -1);
    wait_drain();
    exp_ok++;
    n_cmp++;
    if (stat_frames_ok !== (StatsEn ? exp_ok : 32'd0)) begin
      n_bad++;
      $display("FAIL good_stat_ok: got %0d, required %0d", stat_frames_ok,
               StatsEn ? exp_ok : 32'd0);
    end
  endtask

  task automatic test_crc_error();
    byte_q_t body;
    body = make_body(60);
    body[17] = body[17] ^ 8'h04;
    push_expect(body, 60, 5'b10000, 1'b1);
    drive(with_preamble(body), -1);
    wait_drain();
    exp_crc++;
    n_cmp++;
    if (stat_crc_err !== (StatsEn ? exp_crc : 16'd0)) begin
      n_bad++;
      $display("FAIL crc_stat: got %0d, required %0d", stat_crc_err, StatsEn ? exp_crc : 16'd0);
    end
  endtask

  task automatic test_bad_preamble();
    byte_q_t f;
    byte_q_t body;
    f.push_back(8'h55);
    f.push_back(8'h55);
    f.push_back(8'h5D);
    for (int i = 0; i < 10; i++) f.push_back(8'hA5);
    drive(f, -1);
    f.delete();
    for (int i = 0; i < 8; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 0; i < 70; i++) f.push_back(8'h3C);
    drive(f, -1);
    body = make_body(64);
    push_expect(body, 64, 5'b00000, 1'b1);
    drive(with_preamble(body), -1);
    wait_drain();
    exp_other += 16'd2;
    exp_ok++;
    n_cmp++;
    if (stat_other_err !== (StatsEn ? exp_other : 16'd0)) begin
      n_bad++;
      $display("FAIL preamble_stat: got %0d, required %0d", stat_other_err,
               StatsEn ? exp_other : 16'd0);
    end
    n_cmp++;
    if (stat_frames_ok !== (StatsEn ? exp_ok : 32'd0)) begin
      n_bad++;
      $display("FAIL preamble_follow_ok: got %0d, required %0d", stat_frames_ok,
               StatsEn ? exp_ok : 32'd0);
    end
  endtask

  task automatic test_runts();
    byte_q_t body;
    body = make_body(36);
    push_expect(body, 36, 5'b00100, 1'b1);
    drive(with_preamble(body), -1);
    body = make_body(1);
    push_expect(body, 1, 5'b00100, 1'b1);
    drive(with_preamble(body), -1);
    body = make_body(0);
    drive(with_preamble(body), -1);
    wait_drain();
    exp_other += 16'd3;
    n_cmp++;
    if (stat_other_err !== (StatsEn ? exp_other : 16'd0)) begin
      n_bad++;
      $display("FAIL runt_stat: got %0d, required %0d", stat_other_err,
               StatsEn ? exp_other : 16'd0);
    end
  endtask

  task automatic test_rx_er();
    byte_q_t body;
    body = make_body(60);
    push_expect(body, 60, 5'b00010, 1'b1);
    drive(with_preamble(body), 8 + 30);
    wait_drain();
    exp_other++;
    n_cmp++;
    if (stat_other_err !== (StatsEn ? exp_other : 16'd0)) begin
      n_bad++;
      $display("FAIL rx_er_stat: got %0d, required %0d", stat_other_err,
               StatsEn ? exp_other : 16'd0);
    end
  endtask

  task automatic test_lengths();
    byte_q_t body;
    body = make_body(1596);
    push_expect(body, 1519, 5'b01000, 1'b1);
    drive(with_preamble(body), -1);
    body = make_body(1518);
    push_expect(body, 1518, 5'b00000, 1'b1);
    drive(with_preamble(body), -1);
    wait_drain();
    exp_other++;
    exp_ok++;
    n_cmp++;
    if (stat_other_err !== (StatsEn ? exp_other : 16'd0)) begin
      n_bad++;
      $display("FAIL giant_stat: got %0d, required %0d", stat_other_err,
               StatsEn ? exp_other : 16'd0);
    end
    n_cmp++;
    if (stat_frames_ok !== (StatsEn ? exp_ok : 32'd0)) begin
      n_bad++;
      $display("FAIL max_len_ok: got %0d, required %0d", stat_frames_ok,
               StatsEn ? exp_ok : 32'd0);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t a;
    byte_q_t b;
    a = make_body(60);
    b = make_body(96);
    push_expect(a, 60, 5'b00000, 1'b1);
    push_expect(b, 96, 5'b00000, 1'b1);
    drive(with_preamble(a), -1);
    drive(with_preamble(b), -1);
    wait_drain();
    exp_ok += 32'd2;
    n_cmp++;
    if (stat_frames_ok !== (StatsEn ? exp_ok : 32'd0)) begin
      n_bad++;
      $display("FAIL b2b_stat_ok: got %0d, required %0d", stat_frames_ok,
               StatsEn ? exp_ok : 32'd0);
    end
  endtask

  task automatic test_reset_midframe();
    byte_q_t body;
    byte_q_t f;
    body = make_body(60);
    f    = with_preamble(body);
    push_expect(body, 15, 5'b00000, 1'b0);
    for (int i = 0; i < 8 + 20; i++) begin
      @(negedge GMII_RX_CLK);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = f[i];
    end
    @(negedge GMII_RX_CLK);
    reset    = 1'b1;
    gmii_rxd = f[28];
    @(negedge GMII_RX_CLK);
    n_cmp++;
    if ({out_data, out_valid, out_sof, out_eof, out_good, out_err} !== 17'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h, required 0",
               {out_data, out_valid, out_sof, out_eof, out_good, out_err});
    end
    n_cmp++;
    if ({stat_frames_ok, stat_crc_err, stat_other_err} !== 64'd0) begin
      n_bad++;
      $display("FAIL midreset_stats: got %0d/%0d/%0d, required 0/0/0",
               stat_frames_ok, stat_crc_err, stat_other_err);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL midreset_pending: got %0d beats outstanding, required 0", sb.size());
      sb.delete();
    end
    reset      = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    exp_ok     = '0;
    exp_crc    = '0;
    exp_other  = '0;
    @(negedge GMII_RX_CLK);
    body = make_body(70);
    push_expect(body, 70, 5'b00000, 1'b1);
    drive(with_preamble(body), -1);
    wait_drain();
    exp_ok++;
    n_cmp++;
    if (stat_frames_ok !== (StatsEn ? exp_ok : 32'd0)) begin
      n_bad++;
      $display("FAIL post_reset_ok: got %0d, required %0d", stat_frames_ok,
               StatsEn ? exp_ok : 32'd0);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_ok    = '0;
    exp_crc   = '0;
    exp_other = '0;
    test_reset();
    test_good_frame();
    test_crc_error();
    test_bad_preamble();
    test_runts();
    test_rx_er();
    test_lengths();
    test_back_to_back();
    test_reset_midframe();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL final_drain: got %0d beats outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gmii_rx_frame_check.md
# gmii_rx_frame_check

GMII receive front end on `GMII_RX_CLK`, placed between the RGMII DDR input stage and the MAC RX buffer writer. It strips the preamble and SFD, then checks the FCS, frame length and `GMII_RX_ER`. It presents the frame body (destination MAC through the last payload byte, FCS removed) as a byte stream with start/end markers and a good/bad verdict on the last byte. The downstream writer commits the frame only when `out_good` is set; otherwise it discards it.

## Interface
- `MIN_FRAME_BYTES`, 64: minimum frame length, counted from the destination MAC through the FCS inclusive.
- `MAX_FRAME_BYTES`, 1522: maximum frame length, counted the same way.
- `GMII_RX_CLK`  in  1  receive clock. Reset is `reset`, synchronous, active-high; clock is `GMII_RX_CLK`.
- `reset`  in  1  synchronous, active-high.
- `gmii_rxd`  in  8  receive byte.
- `gmii_rx_dv`  in  1  data valid.
- `gmii_rx_er`  in  1  receive error.
- `out_data`  out  8  frame byte.
- `out_valid`  out  1  `out_data` is valid this cycle.
- `out_sof`  out  1  first byte of the frame (destination MAC byte 0); qualified by `out_valid`.
- `out_eof`  out  1  last payload byte; qualified by `out_valid`.
- `out_good`  out  1  frame verdict; meaningful only with `out_eof`.
- `out_err`  out  5  error flags, sampled with `out_eof`:
  - [0] preamble/SFD
  - [1] `gmii_rx_er`
  - [2] runt
  - [3] giant
  - [4] CRC
- `stat_frames_ok`  out  32  count of good frames.
- `stat_crc_err`  out  16  count of CRC errors.
- `stat_other_err`  out  16  count of all other errors.

## Operation
- State machine: IDLE, PRE, BODY, DROP.
- IDLE → PRE when `gmii_rx_dv`=1 and `gmii_rxd`=0x55.
  - DV high with any other byte → DROP; the preamble error is counted.
- PRE:
  - Stays in PRE on 0x55, for up to 7 bytes.
  - → BODY on 0xD5.
  - Any other byte, or an 8th 0x55 → DROP; preamble error counted; nothing is emitted.
  - DV low → IDLE silently.
- BODY: each sampled byte goes into the CRC and enters a 5-stage delay line.
  - Byte counter `n` is 11 bits, saturating, and counts body bytes including the FCS.
  - Each sampled byte pushes the oldest held byte out once 5 bytes are held, so a byte is emitted 5 bytes after it arrives; the last payload byte is emitted when DV low is sampled.
  - The first emitted byte carries `out_sof`.
- BODY exit on DV low:
  - The last payload byte is emitted with `out_eof`=1.
  - `out_good` = no error flag set. The CRC check passes when the running CRC equals residue 0xC704DD7B. The CRC is seeded 0xFFFFFFFF and fed bit-reversed bytes through `crc32_d8`.
  - Runt: `n` < `MIN_FRAME_BYTES`.
  - `n` ≤ 4: nothing is emitted; only the counters update.
  - Next state IDLE.
- `gmii_rx_er`=1 in BODY sets `out_err[1]`; the frame continues to the end and the verdict is bad.
- Giant: `n` reaches `MAX_FRAME_BYTES`+1.
  - The held byte is emitted immediately with `out_eof`=1, `out_good`=0, `out_err[3]`=1.
  - → DROP.
- DROP: nothing is emitted. → IDLE on DV low.
- Minimum inter-frame gap is 1 cycle of DV low. The DV-low cycle that produces `out_eof` also returns the state machine to IDLE, so a new frame may start on the next cycle.
- Reset mid-frame: on the next cycle all outputs are 0 and the state is IDLE. No `out_eof` is produced; the downstream block shares the same reset.

## Timing
- All outputs are registered. Reset values are 0 for every output, including the statistics counters.
- In-frame latency: byte k sampled at edge e_k appears after edge e_{k+5}, where e_N is the edge that samples DV low.
- `out_valid` is contiguous from `out_sof` to `out_eof`; a frame has no gaps, because GMII delivers back-to-back bytes.
- `out_sof` and `out_eof` assert in the same cycle when exactly one payload byte exists (`n`=5).
- The counters update on the cycle after the verdict and saturate at all-ones.

## Configuration
- `GMII_RX_STATS_EN`
  - Defined: the three statistics counters are built.
  - Undefined: the `stat_*` ports remain and are driven constant 0; no counter logic is synthesized.

## Structure
- Shared package `gmii_rx_pkg` holds:
  - the state enum;
  - the error-bit index constants;
  - the CRC residue constant (0xC704DD7B);
  - the CRC seed constant (0xFFFFFFFF).
- Reuses the existing `crc32_d8` combinational sub-module. No other sub-modules.

## Test plan
- 7×0x55 + 0xD5 + 60-byte body with valid FCS (64 bytes total):
  - 60 beats out; `out_sof` on beat 0, `out_eof` on beat 59; `out_good`=1, `out_err`=0.
  - `stat_frames_ok`=1.
- Same frame with one payload bit flipped → `out_good`=0, `out_err`=5'b10000, `stat_crc_err`=1.
- Preamble 0x55,0x55,0x5D:
  - no `out_valid` at all; `stat_other_err`=1.
  - A valid frame following after one idle cycle is accepted with `out_good`=1.
- 1600-byte body: `out_eof` on beat 1518, `out_err[3]`=1, `out_good`=0; DROP persists until DV low.
- 40-byte body with valid FCS → 36 beats out, `out_err[2]`=1, `out_good`=0.
- Reset asserted at body byte 20 → next cycle all outputs 0; a subsequent valid frame passes cleanly.
